// File: rtl/lcd_nibble_tx_if.sv
`default_nettype none
// ============================================================================
// lcd_nibble_tx_if : request/acknowledge command bus between an LCD requester
//                    and the lcd_nibble_tx responder.
// Rev 1.0
// ============================================================================
interface lcd_nibble_tx_if #(
  parameter int DEL_W_P = 18
);
  logic               rq_i;
  logic               ack_o;
  logic               rqRs_i;
  logic               rqRw_i;
  logic [3:0]         rqData_i;
  logic [DEL_W_P-1:0] rqDel_i;
  logic               busy_o;

  modport master (
    output rq_i, rqRs_i, rqRw_i, rqData_i, rqDel_i,
    input  ack_o, busy_o
  );

  modport slave (
    input  rq_i, rqRs_i, rqRw_i, rqData_i, rqDel_i,
    output ack_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// lcd_nibble_tx : drives one 4-bit LCD command with setup / enable / hold
//                 timing, waits the requested delay, then acknowledges.
// Rev 1.0
// ============================================================================
module lcd_nibble_tx #(
  parameter int SETUP_P   = 2,
  parameter int E_WIDTH_P = 12,
  parameter int HOLD_P    = 1,
  parameter int DEL_W_P   = 18
) (
  input  wire          clk_i,
  input  wire          reset_i,
  lcd_nibble_tx_if.slave cmd,
  output logic         lcd_rs_o,
  output logic         lcd_rw_o,
  output logic         lcd_e_o,
  output logic [3:0]   lcd_data_o,
  output logic         lcd_data_oe_o,
  input  wire  [3:0]   lcd_data_i,
  output logic [3:0]   rdData_o
);

  // One shared phase counter covers setup, enable and hold; size it for the longest.
  localparam int c_PH_MAX = (SETUP_P > E_WIDTH_P)
                          ? ((SETUP_P   > HOLD_P) ? SETUP_P   : HOLD_P)
                          : ((E_WIDTH_P > HOLD_P) ? E_WIDTH_P : HOLD_P);
  localparam int c_PH_W   = (c_PH_MAX < 2) ? 1 : $clog2(c_PH_MAX);

  localparam logic [c_PH_W-1:0] c_SETUP_LD = c_PH_W'(SETUP_P - 1);
  localparam logic [c_PH_W-1:0] c_EW_LD    = c_PH_W'(E_WIDTH_P - 1);
  localparam logic [c_PH_W-1:0] c_HOLD_LD  = c_PH_W'(HOLD_P - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  state_t               r_state,   w_state;
  logic [c_PH_W-1:0]    r_phCnt,   w_phCnt;
  logic [DEL_W_P-1:0]   r_delCnt,  w_delCnt;
  logic [DEL_W_P-1:0]   r_del,     w_del;
  logic                 r_lcdRs,   w_lcdRs;
  logic                 r_lcdRw,   w_lcdRw;
  logic [3:0]           r_lcdData, w_lcdData;
  logic                 r_lcdE,    w_lcdE;
  logic                 r_oe,      w_oe;
  logic                 r_ack,     w_ack;
  logic                 r_busy,    w_busy;
  logic [3:0]           r_rdData,  w_rdData;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_phCnt   <= '0;
      r_delCnt  <= '0;
      r_del     <= '0;
      r_lcdRs   <= 1'b0;
      r_lcdRw   <= 1'b0;
      r_lcdData <= 4'h0;
      r_lcdE    <= 1'b0;
      r_oe      <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdData  <= 4'h0;
    end else begin
      r_state   <= w_state;
      r_phCnt   <= w_phCnt;
      r_delCnt  <= w_delCnt;
      r_del     <= w_del;
      r_lcdRs   <= w_lcdRs;
      r_lcdRw   <= w_lcdRw;
      r_lcdData <= w_lcdData;
      r_lcdE    <= w_lcdE;
      r_oe      <= w_oe;
      r_ack     <= w_ack;
      r_busy    <= w_busy;
      r_rdData  <= w_rdData;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_phCnt   = r_phCnt;
    w_delCnt  = r_delCnt;
    w_del     = r_del;
    w_lcdRs   = r_lcdRs;
    w_lcdRw   = r_lcdRw;
    w_lcdData = r_lcdData;
    w_lcdE    = r_lcdE;
    w_oe      = r_oe;
    w_ack     = 1'b0;
    w_busy    = r_busy;
    w_rdData  = r_rdData;

    case (r_state)
      ST_IDLE: begin
        if (cmd.rq_i) begin
          w_lcdRs   = cmd.rqRs_i;
          w_lcdRw   = cmd.rqRw_i;
          w_lcdData = cmd.rqData_i;
          w_del     = cmd.rqDel_i;
          w_oe      = ~cmd.rqRw_i;
          w_busy    = 1'b1;
          w_phCnt   = c_SETUP_LD;
          w_state   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (r_phCnt == '0) begin
          w_lcdE  = 1'b1;
          w_phCnt = c_EW_LD;
          w_state = ST_PULSE;
        end else begin
          w_phCnt = r_phCnt - 1'b1;
        end
      end

      ST_PULSE: begin
        if (r_phCnt == '0) begin
          // Sample the pads at the close of the enable pulse, when LCD read data is valid.
          if (r_lcdRw) begin
            w_rdData = lcd_data_i;
          end
          w_lcdE  = 1'b0;
          w_phCnt = c_HOLD_LD;
          w_state = ST_HOLD;
        end else begin
          w_phCnt = r_phCnt - 1'b1;
        end
      end

      ST_HOLD: begin
        if (r_phCnt == '0) begin
          if (r_del == '0) begin
            w_ack   = 1'b1;
            w_state = ST_ACK;
          end else begin
            w_delCnt = r_del - 1'b1;
            w_state  = ST_WAIT;
          end
        end else begin
          w_phCnt = r_phCnt - 1'b1;
        end
      end

      ST_WAIT: begin
        if (r_delCnt == '0) begin
          w_ack   = 1'b1;
          w_state = ST_ACK;
        end else begin
          w_delCnt = r_delCnt - 1'b1;
        end
      end

      ST_ACK: begin
        w_busy  = 1'b0;
        w_oe    = 1'b0;
        w_lcdE  = 1'b0;
        w_state = ST_IDLE;
      end

      default: begin
        w_busy  = 1'b0;
        w_oe    = 1'b0;
        w_lcdE  = 1'b0;
        w_state = ST_IDLE;
      end
    endcase
  end

  assign cmd.ack_o     = r_ack;
  assign cmd.busy_o    = r_busy;
  assign lcd_rs_o      = r_lcdRs;
  assign lcd_rw_o      = r_lcdRw;
  assign lcd_e_o       = r_lcdE;
  assign lcd_data_o    = r_lcdData;
  assign lcd_data_oe_o = r_oe;
  assign rdData_o      = r_rdData;

endmodule
`default_nettype wire

// File: tb/tb_lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// tb_lcd_nibble_tx : randomized self-checking bench for lcd_nibble_tx using a
//                    command-timeline reference model.
// Rev 1.0
// ============================================================================
module tb_lcd_nibble_tx;
  localparam int S       = 2;
  localparam int EW      = 12;
  localparam int H       = 1;
  localparam int DW      = 14;
  localparam int DEL_MAX = (1 << DW) - 1;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       lcdRs, lcdRw, lcdE, lcdOe;
  logic [3:0] lcdData, lcdDataIn, rdData;

  int         testCnt = 0;
  int         failCnt = 0;
  logic [3:0] expRd   = 4'h0;
  logic [5:0] expPins = 6'h0;
  int         eRise   = 0;
  int         ackCnt  = 0;
  logic       ePrev   = 1'b0;

  always #5 clk = ~clk;

  lcd_nibble_tx_if #(.DEL_W_P(DW)) cmdIf ();

  lcd_nibble_tx #(
    .SETUP_P  (S),
    .E_WIDTH_P(EW),
    .HOLD_P   (H),
    .DEL_W_P  (DW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cmd          (cmdIf),
    .lcd_rs_o     (lcdRs),
    .lcd_rw_o     (lcdRw),
    .lcd_e_o      (lcdE),
    .lcd_data_o   (lcdData),
    .lcd_data_oe_o(lcdOe),
    .lcd_data_i   (lcdDataIn),
    .rdData_o     (rdData)
  );

  always @(negedge clk) begin
    if (lcdE && !ePrev) eRise++;
    if (cmdIf.ack_o) ackCnt++;
    ePrev = lcdE;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      checkVal("idle_busy", 32'(cmdIf.busy_o), 32'(0));
      checkVal("idle_e",    32'(lcdE),         32'(0));
      checkVal("idle_ack",  32'(cmdIf.ack_o),  32'(0));
      checkVal("idle_oe",   32'(lcdOe),        32'(0));
      checkVal("idle_pins", 32'({lcdRs, lcdRw, lcdData}), 32'(expPins));
      checkVal("idle_rd",   32'(rdData),       32'(expRd));
    end
  endtask

  // Model: accept at edge 0; E high for edges [S, S+EW); ack at edge S+EW+H+del;
  // read data sampled at edge S+EW; busy/oe through the ack edge.
  task automatic runCmd(input logic rs, input logic rw, input logic [3:0] data,
                        input logic [DW-1:0] del, input logic [3:0] rdVal, input int dropAt);
    int L;
    L = S + EW + H + int'(del);
    cmdIf.rq_i     = 1'b1;
    cmdIf.rqRs_i   = rs;
    cmdIf.rqRw_i   = rw;
    cmdIf.rqData_i = data;
    cmdIf.rqDel_i  = del;
    lcdDataIn      = ~rdVal;
    for (int n = 0; n <= L + 1; n++) begin
      @(negedge clk);
      if (rw && n == S + EW) expRd = rdVal;
      checkVal("busy",   32'(cmdIf.busy_o), 32'(n <= L));
      checkVal("lcd_e",  32'(lcdE),         32'(n >= S && n < S + EW));
      checkVal("ack",    32'(cmdIf.ack_o),  32'(n == L));
      checkVal("oe",     32'(lcdOe),        32'((n <= L) && !rw));
      checkVal("pins",   32'({lcdRs, lcdRw, lcdData}), 32'({rs, rw, data}));
      checkVal("rdData", 32'(rdData),       32'(expRd));
      if (n == dropAt) begin
        cmdIf.rq_i     = 1'b0;
        cmdIf.rqRs_i   = 1'($urandom);
        cmdIf.rqRw_i   = 1'($urandom);
        cmdIf.rqData_i = 4'($urandom);
        cmdIf.rqDel_i  = DW'($urandom);
      end
      lcdDataIn = (rw && n >= S && n < S + EW) ? rdVal : ~rdVal;
    end
    expPins = {rs, rw, data};
  endtask

  initial begin
    int e0, a0, gap, drop;
    logic [DW-1:0] d;

    reset_i        = 1'b1;
    cmdIf.rq_i     = 1'b0;
    cmdIf.rqRs_i   = 1'b0;
    cmdIf.rqRw_i   = 1'b0;
    cmdIf.rqData_i = 4'h0;
    cmdIf.rqDel_i  = '0;
    lcdDataIn      = 4'h0;
    repeat (3) @(negedge clk);
    checkVal("rst_ack",  32'(cmdIf.ack_o),  32'(0));
    checkVal("rst_busy", 32'(cmdIf.busy_o), 32'(0));
    checkVal("rst_e",    32'(lcdE),         32'(0));
    checkVal("rst_pins", 32'({lcdRs, lcdRw, lcdData}), 32'(0));
    checkVal("rst_oe",   32'(lcdOe),        32'(0));
    checkVal("rst_rd",   32'(rdData),       32'(0));
    reset_i = 1'b0;
    idleCycles(3);

    // Long write, zero-delay write, maximum delay (no wrap)
    runCmd(1'b0, 1'b0, 4'h3, DW'(12000), 4'h0, -1);
    cmdIf.rq_i = 1'b0;
    idleCycles(2);
    runCmd(1'b0, 1'b0, 4'h2, '0, 4'h0, -1);
    cmdIf.rq_i = 1'b0;
    idleCycles(1);
    runCmd(1'b1, 1'b0, 4'h9, DW'(DEL_MAX), 4'h0, -1);
    cmdIf.rq_i = 1'b0;
    idleCycles(1);

    // Read capture, then a command whose fields change and rq drops mid-flight
    runCmd(1'b1, 1'b1, 4'h0, DW'(50), 4'hA, -1);
    cmdIf.rq_i = 1'b0;
    idleCycles(2);
    runCmd(1'b1, 1'b0, 4'h5, DW'(7), 4'h0, 5);
    idleCycles(2);

    // Thirteen back-to-back commands, accepted in the first idle cycle each time
    e0 = eRise;
    a0 = ackCnt;
    for (int i = 0; i < 13; i++) begin
      runCmd(1'($urandom), 1'b0, 4'($urandom), DW'($urandom_range(0, 20)), 4'h0, -1);
    end
    cmdIf.rq_i = 1'b0;
    idleCycles(2);
    checkVal("b2b_epulses", 32'(eRise - e0),  32'(13));
    checkVal("b2b_acks",    32'(ackCnt - a0), 32'(13));

    // Reset while E is high
    cmdIf.rq_i     = 1'b1;
    cmdIf.rqRs_i   = 1'b1;
    cmdIf.rqRw_i   = 1'b0;
    cmdIf.rqData_i = 4'hC;
    cmdIf.rqDel_i  = DW'(30);
    repeat (S + 4) @(negedge clk);
    checkVal("pre_rst_e", 32'(lcdE), 32'(1));
    a0 = ackCnt;
    #2 reset_i = 1'b1;
    cmdIf.rq_i = 1'b0;
    #1;
    checkVal("arst_e",    32'(lcdE),         32'(0));
    checkVal("arst_busy", 32'(cmdIf.busy_o), 32'(0));
    checkVal("arst_pins", 32'({lcdRs, lcdRw, lcdData}), 32'(0));
    checkVal("arst_oe",   32'(lcdOe),        32'(0));
    expRd   = 4'h0;
    expPins = 6'h0;
    @(negedge clk);
    reset_i = 1'b0;
    idleCycles(40);
    checkVal("arst_noack", 32'(ackCnt - a0), 32'(0));
    runCmd(1'b0, 1'b1, 4'h1, DW'(3), 4'h6, -1);
    cmdIf.rq_i = 1'b0;
    idleCycles(1);

    // Randomized commands with random gaps and occasional mid-command rq drops
    for (int i = 0; i < 30; i++) begin
      d    = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 1)) : DW'($urandom_range(0, 40));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      runCmd(1'($urandom), 1'($urandom), 4'($urandom), d, 4'($urandom), drop);
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        cmdIf.rq_i = 1'b0;
        idleCycles(gap);
      end
    end
    cmdIf.rq_i = 1'b0;
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
`default_nettype wire
